// File: rtl/multicycle_ctrl_if.sv
// Decode inputs and control outputs of the multicycle RISC-V controller.
// The slave side is the controller; the master side is the surrounding datapath.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       illegal;
    logic [3:0] state;

    modport master (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, state
    );

    modport slave (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM (lw, sw, R-type, I-ALU, beq, jal).
// Moore state outputs plus combinational PCWrite, ALUControl, ImmSrc and illegal.
module multicycle_ctrl (
    input  logic             clk,
    input  logic             reset,
    multicycle_ctrl_if.slave bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0] state_q, state_d;
    logic       op_known;
    logic       pc_update, branch, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       illegal_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        op_known = 1'b0;
        case (bus.op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_known = 1'b1;
            default:                                  op_known = 1'b0;
        endcase
    end

    // Unused encodings 11-15 fall through the default back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
            S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; end
            S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
            S_EXECUTER: begin alu_src_a = 2'b10; alu_op = 2'b10; end
            S_EXECUTEI: begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ:      begin alu_src_a = 2'b10; alu_op = 2'b01; branch = 1'b1; end
            S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_update = 1'b1; end
            default:    ;
        endcase

        illegal_raw = (state_q == S_DECODE) && !op_known;

        bus.ALUControl = 3'b000;
        case (alu_op)
            2'b01: bus.ALUControl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.ALUControl = 3'b101;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            default: bus.ALUControl = 3'b000;
        endcase

        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase

        // Strobes are masked while reset is low; the state register already reads FETCH.
        bus.PCWrite   = reset & (pc_update | (branch & bus.zero));
        bus.IRWrite   = reset & ir_write;
        bus.RegWrite  = reset & reg_write;
        bus.MemWrite  = reset & mem_write;
        bus.illegal   = reset & illegal_raw;
        bus.AdrSrc    = adr_src;
        bus.ResultSrc = result_src;
        bus.ALUSrcA   = alu_src_a;
        bus.ALUSrcB   = alu_src_b;
        bus.state     = state_q;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings below are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 op  input  7  instruction opcode from instruction register.
REQ-005 funct3  input  3  instruction funct3.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU zero flag, same cycle.
REQ-008 PCWrite  output  1  PC register load enable.
REQ-009 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 IRWrite  output  1  instruction register and OldPC load enable.
REQ-011 MemWrite  output  1  data memory write enable.
REQ-012 RegWrite  output  1  register file write enable.
REQ-013 ResultSrc  output  2  result select: 00 ALUOut, 01 memory data, 10 ALU result.
REQ-014 ALUSrcA  output  2  ALU A select: 00 PC, 01 OldPC, 10 rs1.
REQ-015 ALUSrcB  output  2  ALU B select: 00 rs2, 01 immediate, 10 constant 4.
REQ-016 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-017 ImmSrc  output  2  00 I-type, 01 S-type, 10 B-type, 11 J-type.
REQ-018 illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-019 state  output  4  current FSM state, for debug.

Function
REQ-020 States, with encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Encodings 11-15 SHALL go to FETCH on the next edge.
REQ-021 Transitions: FETCH->DECODE always.
  - DECODE: lw 0000011 or sw 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other opcode -> FETCH with illegal=1 for that cycle.
  - MEMADR: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
  - MEMREAD->MEMWB; EXECUTER, EXECUTEI, JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
REQ-022 Outputs SHALL be Moore functions of state, except PCWrite, ALUControl, ImmSrc and illegal. Any field not listed for a state SHALL be 0.
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01.
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-023 PCWrite SHALL equal PCUpdate OR (Branch AND zero), combinationally.
REQ-024 ALUControl SHALL be decoded from ALUOp as follows.
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, funct3 000 -> 001 if op[5] AND funct7b5, else 000.
  - ALUOp 10, funct3 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000.
REQ-025 ImmSrc SHALL be decoded from op in every state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, all others -> 00.
REQ-026 Cycles per instruction, counted from FETCH to the next FETCH: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4, illegal 2.
REQ-027 The controller SHALL apply no stall or handshake; memory SHALL be single-cycle.

Reset
REQ-028 When reset=0, the state register SHALL go to FETCH asynchronously.
REQ-029 While reset=0, PCWrite, IRWrite, RegWrite, MemWrite and illegal SHALL be forced to 0; the other outputs SHALL show their FETCH values.
REQ-030 If reset is asserted in any state mid-instruction, no write strobe SHALL assert afterwards.
REQ-031 After reset release, the first rising edge SHALL execute FETCH with strobes enabled.

Verification
REQ-032 lw (op=0000011): state sequence 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in state 4; AdrSrc=1 in state 3.
REQ-033 R-type sub (op=0110011, funct3=000, funct7b5=1): ALUControl=001 in EXECUTER; RegWrite=1 in ALUWB; CPI is 4.
REQ-034 beq with zero=1: PCWrite=1 in BEQ and ImmSrc=10. Repeating with zero=0: PCWrite=0 in BEQ.
REQ-035 Illegal op=1111111: DECODE->FETCH, illegal=1 for exactly one cycle, no RegWrite or MemWrite pulse.
REQ-036 Assert reset=0 asynchronously while in MEMWRITE: state=0 immediately and MemWrite=0; after release, a FETCH cycle follows with IRWrite=1 and PCWrite=1.
